alu_cntrl_q: RTL and testbench
==============================

Name: alu_cntrl_q

Overview:
- Parametrised, queued successor to the combinational ALU control decoder.
- Accepts opCode/funct with a tag over a valid/ready handshake and decodes each into the ALU control word {aluOp, invA, invB, Cin, sign}.
- Buffers decoded words in a DEPTH-entry FIFO and presents them in order to the execute stage over a second valid/ready handshake.
- Supports pipeline flush and decouples decode from execute stalls.

Parameters:
- OPW, 5: opCode width. Bits above [4:0] must be zero, otherwise the default decode applies.
- FW, 2: funct width. Only funct[1:0] is decoded.
- DEPTH, 2: FIFO entries, >=1, any integer (not limited to powers of two).
- TAGW, 4: width of the opaque tag carried alongside each entry.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer offers an instruction.
- in_ready  out  1  block can accept; equals (count < DEPTH).
- in_opCode  in  OPW  instruction opcode.
- in_funct  in  FW  instruction funct field.
- in_tag  in  TAGW  tag stored with the entry.
- flush  in  1  discard all queued entries.
- out_valid  out  1  head entry valid; equals (count != 0).
- out_ready  in  1  consumer takes the head entry.
- aluOp  out  3  head entry: 000 rol, 001 sll, 010 ror, 011 srl, 100 add, 101 or, 110 xor, 111 and.
- invA, invB, Cin, sign  out  1 each  head entry control bits.
- out_tag  out  TAGW  head entry tag.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Decode table, written as opCode[/funct] -> aluOp invA invB Cin sign:
  - 01000 -> 100 0 0 0 1
  - 01001 -> 100 1 0 1 1
  - 01010 -> 110 0 0 0 0
  - 01011 -> 111 0 1 0 0
  - 10100..10111 -> 000..011, all flags 0
  - 11011/00 -> 100 0 0 0 1; /01 -> 100 1 0 1 1; /10 -> 110 0 0 0 0; /11 -> 111 0 1 0 0
  - 11010/00..11 -> 000..011, all flags 0
  - 11100, 11101, 11110 -> 100 0 1 1 1
  - 11111 -> 100 0 0 0 0
  - 10000, 10001, 10011 -> 100 0 0 0 1
  - every other code -> 100 0 0 0 0
- Push: occurs when in_valid & in_ready; the decoded word and tag are written at the tail.
- Pop: occurs when out_valid & out_ready; the head advances.
- Latency: a word pushed in cycle N is visible on the outputs in cycle N+1 if the FIFO was empty.
- Simultaneous push and pop: count is unchanged and order is preserved.
- Full: in_ready is 0 and there is no push-when-full, even with a same-cycle pop.
- Empty: out_valid is 0; aluOp/flags/out_tag hold the last head value and are don't-care for checking.
- Pointers: read/write pointers wrap modulo DEPTH.
- Flush: count becomes 0 next cycle and read/write pointers are reset. Flush overrides a same-cycle push and pop; neither takes effect.
- Reset, including mid-operation: count=0, pointers=0, out_valid=0, in_ready=1, aluOp=100, invA=invB=Cin=sign=0, out_tag=0.
- Control state: the FSM is implicit in the count encoding: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).

Optional Feature:
- ALU_CNTRL_Q_BYPASS_EN defined:
  - When count==0, in_valid=1 and out_ready=1, the decoded word is driven combinationally onto the outputs.
  - out_valid=1 in the same cycle and nothing is written, giving zero latency.
  - in_ready stays (count<DEPTH).
  - flush=1 suppresses the bypass (out_valid=0).
- Macro undefined: every word passes through the FIFO with a minimum latency of 1 cycle.

Decomposition:
- Package alu_cntrl_pkg:
  - opcode localparams (OP_ADDI, OP_RRR=11011, OP_SHR=11010, ...)
  - aluOp encodings (ALU_ROL..ALU_AND)
  - 7-bit control-word layout {aluOp, invA, invB, Cin, sign}
  - reset control word (1000000)
- Sub-module alu_cntrl_dec: purely combinational opCode/funct -> control word. Instantiated once at the FIFO input; storage and handshakes stay in alu_cntrl_q.

Test Plan:
- Decode sweep: push each opcode/funct listed in the table with out_ready=1 -> each popped word matches the table, e.g. 11011/01 -> aluOp=100 invA=1 invB=0 Cin=1 sign=1.
- Fill/backpressure (DEPTH=2): out_ready=0, push 01000 tag 1 then 01010 tag 2 -> count=2, in_ready=0, and a third push is ignored. Then out_ready=1 -> tags pop in order 1, 2, then count=0.
- Simultaneous push and pop at count=1: push 10101 while popping -> count stays 1, next head aluOp=001.
- Flush with push: count=2, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, and the pushed word is absent.
- Reset mid-stream: count=1, rst=1 for 1 cycle -> count=0, aluOp=100, flags 0, out_tag=0, in_ready=1.
- DEPTH=3 wrap: 10 push/pop pairs with tags 0..9 -> output tag order 0..9, no loss or duplication.

Source files
------------

// File: rtl/alu_cntrl_pkg.sv
// Shared definitions for the queued ALU control decoder: opcodes, ALU op encodings,
// the 7-bit control word and the helper used by the decoder.
package alu_cntrl_pkg;

  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_ROLI  = 5'b10100;
  localparam logic [4:0] OP_SLLI  = 5'b10101;
  localparam logic [4:0] OP_RORI  = 5'b10110;
  localparam logic [4:0] OP_SRLI  = 5'b10111;
  localparam logic [4:0] OP_RRR   = 5'b11011;
  localparam logic [4:0] OP_SHR   = 5'b11010;
  localparam logic [4:0] OP_SEQ   = 5'b11100;
  localparam logic [4:0] OP_SLT   = 5'b11101;
  localparam logic [4:0] OP_SLE   = 5'b11110;
  localparam logic [4:0] OP_SCO   = 5'b11111;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_STU   = 5'b10011;

  localparam logic [2:0] ALU_ROL = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_ROR = 3'b010;
  localparam logic [2:0] ALU_SRL = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       inv_a;
    logic       inv_b;
    logic       cin;
    logic       sign;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = 7'b1000000;

  // Occupancy derived from the entry count; the queue has no other control state.
  typedef enum logic [1:0] {
    StEmpty,
    StPartial,
    StFull
  } occ_e;

  // Shared by the immediate forms (010xx) and the register form keyed on funct.
  function automatic ctrl_t arith_ctrl(input logic [1:0] sel);
    ctrl_t c;
    c = CTRL_RST;
    unique case (sel)
      2'b00: c = '{alu_op: ALU_ADD, inv_a: 1'b0, inv_b: 1'b0, cin: 1'b0, sign: 1'b1};
      2'b01: c = '{alu_op: ALU_ADD, inv_a: 1'b1, inv_b: 1'b0, cin: 1'b1, sign: 1'b1};
      2'b10: c = '{alu_op: ALU_XOR, inv_a: 1'b0, inv_b: 1'b0, cin: 1'b0, sign: 1'b0};
      2'b11: c = '{alu_op: ALU_AND, inv_a: 1'b0, inv_b: 1'b1, cin: 1'b0, sign: 1'b0};
      default: c = CTRL_RST;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_cntrl_q_if.sv
// Producer- and consumer-side handshake bundle of the queued ALU control decoder.
interface alu_cntrl_q_if #(
  parameter int unsigned OPW   = 5,
  parameter int unsigned FW    = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAGW  = 4
) ();
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  in_opCode;
  logic [FW-1:0]   in_funct;
  logic [TAGW-1:0] in_tag;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      aluOp;
  logic            invA;
  logic            invB;
  logic            Cin;
  logic            sign;
  logic [TAGW-1:0] out_tag;
  logic [CW-1:0]   count;

  modport slave (
    input  in_valid, in_opCode, in_funct, in_tag, flush, out_ready,
    output in_ready, out_valid, aluOp, invA, invB, Cin, sign, out_tag, count
  );

  modport master (
    output in_valid, in_opCode, in_funct, in_tag, flush, out_ready,
    input  in_ready, out_valid, aluOp, invA, invB, Cin, sign, out_tag, count
  );
endinterface

// File: rtl/alu_cntrl_dec.sv
// Combinational opCode/funct to ALU control word decoder.
module alu_cntrl_dec
  import alu_cntrl_pkg::*;
#(
  parameter int unsigned OPW = 5,
  parameter int unsigned FW  = 2
) (
  input  logic [OPW-1:0] opCode,
  input  logic [FW-1:0]  funct,
  output ctrl_t          ctrl
);
  logic       hi_zero;
  logic [4:0] op;
  logic [1:0] fn;

  // Any set bit above [4:0] forces the default decode.
  if (OPW > 5) begin : g_hi
    assign hi_zero = ~|opCode[OPW-1:5];
  end else begin : g_no_hi
    assign hi_zero = 1'b1;
  end

  assign op = opCode[4:0];
  assign fn = funct[1:0];

  always_comb begin
    ctrl = CTRL_RST;
    if (hi_zero) begin
      unique case (op)
        OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI: ctrl = arith_ctrl(op[1:0]);
        OP_RRR: ctrl = arith_ctrl(fn);
        OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: ctrl.alu_op = {1'b0, op[1:0]};
        OP_SHR: ctrl.alu_op = {1'b0, fn};
        OP_SEQ, OP_SLT, OP_SLE: begin
          ctrl.inv_b = 1'b1;
          ctrl.cin   = 1'b1;
          ctrl.sign  = 1'b1;
        end
        OP_ST, OP_LD, OP_STU: ctrl.sign = 1'b1;
        default: ctrl = CTRL_RST;
      endcase
    end
  end
endmodule

// File: rtl/alu_cntrl_q.sv
// Queued ALU control decoder: decode at the input, DEPTH-entry FIFO to execute.
// Define ALU_CNTRL_Q_BYPASS_EN for a zero-latency path when the queue is empty.
module alu_cntrl_q
  import alu_cntrl_pkg::*;
#(
  parameter int unsigned OPW   = 5,
  parameter int unsigned FW    = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAGW  = 4
) (
  input logic          clk,
  input logic          rst,
  alu_cntrl_q_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  ctrl_t           dec_ctrl;
  ctrl_t           ctrl_mem_q [DEPTH];
  logic [TAGW-1:0] tag_mem_q  [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q, count_d;
  occ_e            occ;
  logic            push, pop, bypass;
  ctrl_t           head_ctrl;
  logic [TAGW-1:0] head_tag;

  alu_cntrl_dec #(
    .OPW(OPW),
    .FW (FW)
  ) u_dec (
    .opCode(bus.in_opCode),
    .funct (bus.in_funct),
    .ctrl  (dec_ctrl)
  );

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    occ = StPartial;
    if (count_q == '0) begin
      occ = StEmpty;
    end else if (count_q == CW'(DEPTH)) begin
      occ = StFull;
    end
  end

`ifdef ALU_CNTRL_Q_BYPASS_EN
  assign bypass = (occ == StEmpty) & bus.in_valid & bus.out_ready & ~bus.flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word is consumed directly, so it is neither written nor popped.
  assign push = bus.in_valid & bus.in_ready & ~bypass & ~bus.flush;
  assign pop  = (occ != StEmpty) & bus.out_ready & ~bus.flush;

  always_comb begin
    count_d = count_q;
    if (bus.flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_mem_q[i] <= CTRL_RST;
        tag_mem_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      if (bus.flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) begin
          ctrl_mem_q[wptr_q] <= dec_ctrl;
          tag_mem_q[wptr_q]  <= bus.in_tag;
          wptr_q             <= ptr_inc(wptr_q);
        end
        if (pop) begin
          rptr_q <= ptr_inc(rptr_q);
        end
      end
    end
  end

  assign head_ctrl = bypass ? dec_ctrl : ctrl_mem_q[rptr_q];
  assign head_tag  = bypass ? bus.in_tag : tag_mem_q[rptr_q];

  assign bus.in_ready  = (occ != StFull);
  assign bus.out_valid = (occ != StEmpty) | bypass;
  assign bus.aluOp     = head_ctrl.alu_op;
  assign bus.invA      = head_ctrl.inv_a;
  assign bus.invB      = head_ctrl.inv_b;
  assign bus.Cin       = head_ctrl.cin;
  assign bus.sign      = head_ctrl.sign;
  assign bus.out_tag   = head_tag;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_alu_cntrl_q.sv
// Bench for alu_cntrl_q: DEPTH=2 and DEPTH=3 instances share one stimulus stream,
// each checked against its own occupancy model and expected-word queue.
module tb_alu_cntrl_q;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic [4:0] in_opCode = '0;
  logic [1:0] in_funct = '0;
  logic [3:0] in_tag = '0;

  always #5 clk = ~clk;

  alu_cntrl_q_if #(.OPW(5), .FW(2), .DEPTH(2), .TAGW(4)) if2 ();
  alu_cntrl_q_if #(.OPW(5), .FW(2), .DEPTH(3), .TAGW(4)) if3 ();

  assign if2.in_valid  = in_valid;
  assign if2.in_opCode = in_opCode;
  assign if2.in_funct  = in_funct;
  assign if2.in_tag    = in_tag;
  assign if2.flush     = flush;
  assign if2.out_ready = out_ready;
  assign if3.in_valid  = in_valid;
  assign if3.in_opCode = in_opCode;
  assign if3.in_funct  = in_funct;
  assign if3.in_tag    = in_tag;
  assign if3.flush     = flush;
  assign if3.out_ready = out_ready;

  alu_cntrl_q #(.OPW(5), .FW(2), .DEPTH(2), .TAGW(4)) u_dut2 (
    .clk(clk),
    .rst(rst),
    .bus(if2)
  );

  alu_cntrl_q #(.OPW(5), .FW(2), .DEPTH(3), .TAGW(4)) u_dut3 (
    .clk(clk),
    .rst(rst),
    .bus(if3)
  );

  typedef struct packed {
    logic [6:0] ctrl;
    logic [3:0] tag;
  } exp_t;

  typedef struct packed {
    logic [4:0] op;
    logic [1:0] fn;
    logic [6:0] ctrl;
  } vec_t;

  localparam logic [6:0] W_ADD  = 7'b1000001;
  localparam logic [6:0] W_SUB  = 7'b1001011;
  localparam logic [6:0] W_XOR  = 7'b1100000;
  localparam logic [6:0] W_ANDN = 7'b1110100;
  localparam logic [6:0] W_CMP  = 7'b1000111;
  localparam logic [6:0] W_DEF  = 7'b1000000;

  exp_t q2[$];
  exp_t q3[$];
  vec_t vecs[$];
  int   c2 = 0;
  int   c3 = 0;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [10:0] head2();
    return {if2.aluOp, if2.invA, if2.invB, if2.Cin, if2.sign, if2.out_tag};
  endfunction

  function automatic logic [10:0] head3();
    return {if3.aluOp, if3.invA, if3.invB, if3.Cin, if3.sign, if3.out_tag};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addv(input logic [4:0] op, input logic [1:0] fn, input logic [6:0] ctrl);
    vecs.push_back('{op: op, fn: fn, ctrl: ctrl});
  endtask

  // One clock: check both DUTs against the models, then advance the models.
  task automatic step(input logic v, input logic [4:0] op, input logic [1:0] fn,
                      input logic [3:0] tg, input logic ordy, input logic fl,
                      input logic [6:0] ec);
    logic push2, push3, pop2, pop3;
    in_valid  = v;
    in_opCode = op;
    in_funct  = fn;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk("count2", 32'(if2.count), 32'(c2));
    chk("in_ready2", 32'(if2.in_ready), 32'(c2 < 2));
    chk("out_valid2", 32'(if2.out_valid), 32'(c2 != 0));
    if (c2 != 0 && ordy) chk("head2", 32'(head2()), 32'(q2[0]));
    chk("count3", 32'(if3.count), 32'(c3));
    chk("in_ready3", 32'(if3.in_ready), 32'(c3 < 3));
    chk("out_valid3", 32'(if3.out_valid), 32'(c3 != 0));
    if (c3 != 0 && ordy) chk("head3", 32'(head3()), 32'(q3[0]));
    push2 = v && (c2 < 2);
    push3 = v && (c3 < 3);
    pop2  = (c2 != 0) && ordy;
    pop3  = (c3 != 0) && ordy;
    if (fl) begin
      q2.delete();
      q3.delete();
      c2 = 0;
      c3 = 0;
    end else begin
      if (pop2) begin
        void'(q2.pop_front());
        c2--;
      end
      if (pop3) begin
        void'(q3.pop_front());
        c3--;
      end
      if (push2) begin
        q2.push_back('{ctrl: ec, tag: tg});
        c2++;
      end
      if (push3) begin
        q3.push_back('{ctrl: ec, tag: tg});
        c3++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'b0, 2'b0, 4'h0, ordy, 1'b0, W_DEF);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q2.delete();
    q3.delete();
    c2 = 0;
    c3 = 0;
    chk("rst_count2", 32'(if2.count), 32'd0);
    chk("rst_in_ready2", 32'(if2.in_ready), 32'd1);
    chk("rst_out_valid2", 32'(if2.out_valid), 32'd0);
    chk("rst_head2", 32'(head2()), 32'({W_DEF, 4'h0}));
    chk("rst_count3", 32'(if3.count), 32'd0);
    chk("rst_head3", 32'(head3()), 32'({W_DEF, 4'h0}));
  endtask

  initial begin
    int k;
    addv(5'b01000, 2'b11, W_ADD);
    addv(5'b01001, 2'b10, W_SUB);
    addv(5'b01010, 2'b01, W_XOR);
    addv(5'b01011, 2'b00, W_ANDN);
    addv(5'b10100, 2'b11, 7'b0000000);
    addv(5'b10101, 2'b00, 7'b0010000);
    addv(5'b10110, 2'b00, 7'b0100000);
    addv(5'b10111, 2'b00, 7'b0110000);
    addv(5'b11011, 2'b00, W_ADD);
    addv(5'b11011, 2'b01, W_SUB);
    addv(5'b11011, 2'b10, W_XOR);
    addv(5'b11011, 2'b11, W_ANDN);
    addv(5'b11010, 2'b00, 7'b0000000);
    addv(5'b11010, 2'b01, 7'b0010000);
    addv(5'b11010, 2'b10, 7'b0100000);
    addv(5'b11010, 2'b11, 7'b0110000);
    addv(5'b11100, 2'b00, W_CMP);
    addv(5'b11101, 2'b01, W_CMP);
    addv(5'b11110, 2'b10, W_CMP);
    addv(5'b11111, 2'b11, W_DEF);
    addv(5'b10000, 2'b00, W_ADD);
    addv(5'b10001, 2'b01, W_ADD);
    addv(5'b10011, 2'b10, W_ADD);
    addv(5'b00000, 2'b00, W_DEF);
    addv(5'b10010, 2'b01, W_DEF);
    addv(5'b01100, 2'b10, W_DEF);
    addv(5'b11000, 2'b11, W_DEF);

    @(posedge clk);
    #1;
    do_reset();

    // Decode sweep, streaming with the consumer always ready.
    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b1, vecs[i].op, vecs[i].fn, 4'(i), 1'b1, 1'b0, vecs[i].ctrl);
    end
    idle(1'b1, 2);

    // Fill under backpressure; DEPTH=2 drops the third offer, DEPTH=3 keeps it.
    step(1'b1, 5'b01000, 2'b00, 4'd1, 1'b0, 1'b0, W_ADD);
    step(1'b1, 5'b01010, 2'b00, 4'd2, 1'b0, 1'b0, W_XOR);
    step(1'b1, 5'b01011, 2'b00, 4'd3, 1'b0, 1'b0, W_ANDN);
    idle(1'b0, 1);
    idle(1'b1, 4);

    // Simultaneous push and pop at count 1.
    step(1'b1, 5'b01000, 2'b00, 4'd5, 1'b0, 1'b0, W_ADD);
    step(1'b1, 5'b10101, 2'b00, 4'd6, 1'b1, 1'b0, 7'b0010000);
    idle(1'b1, 2);

    // Flush overrides a same-cycle push and pop.
    step(1'b1, 5'b01000, 2'b00, 4'd1, 1'b0, 1'b0, W_ADD);
    step(1'b1, 5'b01001, 2'b00, 4'd2, 1'b0, 1'b0, W_SUB);
    step(1'b1, 5'b01010, 2'b00, 4'd3, 1'b1, 1'b1, W_XOR);
    step(1'b1, 5'b01011, 2'b00, 4'd4, 1'b0, 1'b0, W_ANDN);
    idle(1'b1, 2);

    // Reset with an entry queued.
    step(1'b1, 5'b01001, 2'b00, 4'd7, 1'b0, 1'b0, W_SUB);
    idle(1'b0, 1);
    do_reset();

    // Ten back-to-back push/pop pairs wrap both pointer sets.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'b01011, 2'b00, 4'(i), 1'b1, 1'b0, W_ANDN);
    end
    idle(1'b1, 2);

    // Random offers and consumer stalls with an occasional flush.
    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, vecs.size() - 1));
      step(1'($urandom_range(0, 1)), vecs[k].op, vecs[k].fn, 4'(i), 1'($urandom_range(0, 1)),
           1'(i % 17 == 16), vecs[k].ctrl);
    end
    idle(1'b1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
